// File: rtl/mcs_io_master_pkg.sv
// ---------------------------------------------------------------------------
// mcs_io_master_pkg
//   Shared types and constants for the byte-stream MCS IO bus initiator.
//   - state_t      : controller FSM states
//   - OP_WR/OP_RD  : command opcodes ('W' / 'R')
//   - RSP_*        : response status bytes ('K' ack, 'T' timeout, 'E' error)
//   - shift_in_byte: MSB-first byte accumulation helper
// ---------------------------------------------------------------------------
package mcs_io_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_STROBE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RSP    = 3'd5
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_TMO = 8'h54;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // Bytes arrive MSB first, so each new byte lands in the low lane and
    // everything received so far moves up by one byte.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] cur,
                                                  input logic [7:0]  b);
        return {cur[23:0], b};
    endfunction

endpackage

// File: rtl/mcs_io_master.sv
// ---------------------------------------------------------------------------
// mcs_io_master
//   Command-frame driven initiator for the MCS IO bus. A host streams in
//   frames (opcode, 4 address bytes, and for writes 4 data bytes, all MSB
//   first); the block issues one single-beat IO transaction and streams back
//   a status byte (plus 4 read-data bytes for a successful read).
//
// Parameters
//   TIMEOUT : cycles from the strobe cycle until the transaction is abandoned
//   TW      : timeout counter width, 2**TW > TIMEOUT
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   cmd_data/cmd_valid/cmd_ready  : command byte stream (in)
//   rsp_data/rsp_valid/rsp_ready  : response byte stream (out)
//   io_*                          : MCS IO bus initiator signals
// ---------------------------------------------------------------------------
module mcs_io_master
    import mcs_io_master_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready
);

    // WAIT is left when the incremented count would reach TIMEOUT-1, so the
    // response appears exactly TIMEOUT cycles after the strobe cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

    state_t        state_q,    state_d;
    logic          is_rd_q,    is_rd_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   addr_q,     addr_d;
    logic [31:0]   wdata_q,    wdata_d;
    logic [39:0]   rsp_sr_q,   rsp_sr_d;    // outgoing bytes, head in [39:32]
    logic [2:0]    rsp_left_q, rsp_left_d;  // bytes still to send
    logic [TW-1:0] tmo_q,      tmo_d;

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_fire = cmd_valid && (state_q == ST_IDLE || state_q == ST_ADDR ||
                                    state_q == ST_WDATA);
    assign rsp_fire = rsp_ready && (state_q == ST_RSP);

    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_sr_d   = rsp_sr_q;
        rsp_left_d = rsp_left_q;
        tmo_d      = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_data == OP_WR || cmd_data == OP_RD) begin
                        is_rd_d    = (cmd_data == OP_RD);
                        byte_cnt_d = 2'd0;
                        state_d    = ST_ADDR;
                    end else begin
                        rsp_sr_d   = {RSP_ERR, 32'h0};
                        rsp_left_d = 3'd1;
                        state_d    = ST_RSP;
                    end
                end
            end

            ST_ADDR: begin
                if (cmd_fire) begin
                    addr_d     = shift_in_byte(addr_q, cmd_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 for WDATA
                    if (byte_cnt_q == 2'd3) begin
                        state_d = is_rd_q ? ST_STROBE : ST_WDATA;
                    end
                end
            end

            ST_WDATA: begin
                if (cmd_fire) begin
                    wdata_d    = shift_in_byte(wdata_q, cmd_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_STROBE;
                    end
                end
            end

            ST_STROBE, ST_WAIT: begin
                // io_ready takes priority over the final timeout cycle.
                if (io_ready) begin
                    if (is_rd_q) begin
                        rsp_sr_d   = {RSP_ACK, io_read_data};
                        rsp_left_d = 3'd5;
                    end else begin
                        rsp_sr_d   = {RSP_ACK, 32'h0};
                        rsp_left_d = 3'd1;
                    end
                    state_d = ST_RSP;
                end else if (state_q == ST_STROBE) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_sr_d   = {RSP_TMO, 32'h0};
                    rsp_left_d = 3'd1;
                    state_d    = ST_RSP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_RSP: begin
                if (rsp_fire) begin
                    rsp_sr_d   = {rsp_sr_q[31:0], 8'h00};
                    rsp_left_d = rsp_left_q - 3'd1;
                    if (rsp_left_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            is_rd_q    <= 1'b0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rsp_sr_q   <= 40'h0;
            rsp_left_q <= 3'd0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_rd_q    <= is_rd_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_sr_q   <= rsp_sr_d;
            rsp_left_q <= rsp_left_d;
            tmo_q      <= tmo_d;
        end
    end

    // Strobes are decoded from the state register alone, so they fall the
    // instant reset_n is asserted. cmd_ready is additionally gated by
    // reset_n so every output reads 0 while reset is held.
    assign cmd_ready       = reset_n && (state_q == ST_IDLE || state_q == ST_ADDR ||
                                         state_q == ST_WDATA);
    assign io_addr_strobe  = (state_q == ST_STROBE);
    assign io_write_strobe = (state_q == ST_STROBE) && !is_rd_q;
    assign io_read_strobe  = (state_q == ST_STROBE) &&  is_rd_q;
    assign io_byte_enable  = (state_q == ST_STROBE) ? 4'hF : 4'h0;
    assign io_address      = addr_q;
    assign io_write_data   = wdata_q;
    assign rsp_valid       = (state_q == ST_RSP);
    assign rsp_data        = rsp_sr_q[39:32];

endmodule

// File: tb/tb_mcs_io_master.sv
// ---------------------------------------------------------------------------
// tb_mcs_io_master
//   Directed bench for mcs_io_master (TIMEOUT = 8). A negedge monitor logs
//   strobe cycles and every transferred response byte; directed frames are
//   checked against hand-computed bus values, response bytes and latencies.
// ---------------------------------------------------------------------------
module tb_mcs_io_master;

    logic        clk;
    logic        reset_n;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    mcs_io_master #(.TIMEOUT(8), .TW(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .rsp_data        (rsp_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0]  rsp_q[$];
    int          n_strobe;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_wr, s_rd;
    int          s_cyc;
    int          rise_cyc;
    logic        rsp_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (io_addr_strobe) begin
                n_strobe++;
                s_addr  = io_address;
                s_wdata = io_write_data;
                s_be    = io_byte_enable;
                s_wr    = io_write_strobe;
                s_rd    = io_read_strobe;
                s_cyc   = cyc;
            end
            if (rsp_valid && !rsp_prev) rise_cyc = cyc;
            rsp_prev = rsp_valid;
            if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
        end
    end

    task automatic clear_mon();
        rsp_q.delete();
        n_strobe = 0;
        s_cyc    = 0;
        rise_cyc = -1000;
    endtask

    function automatic logic [7:0] rsp_at(input int i);
        logic [7:0] v;
        v = 8'hxx;
        if (i < rsp_q.size()) v = rsp_q[i];
        return v;
    endfunction

    // ---------------- drivers ----------------
    int acc_cyc;
    int op_cyc;

    task automatic send_byte(input logic [7:0] b);
        int  waited;
        bit  done;
        waited    = 0;
        done      = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 200) begin
                chk_val("cmd_accept_timeout", 64'd0, 64'd1);
                done = 1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[9], input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(fr[i]);
            if (i == 0) op_cyc = acc_cyc;
        end
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int w;
        w = 0;
        while (rsp_q.size() < n && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk_val({tag, "_rsp_count"}, rsp_q.size(), n);
    endtask

    task automatic wait_strobe(input string tag);
        int w;
        w = 0;
        while (!io_addr_strobe && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk_val({tag, "_strobe_seen"}, io_addr_strobe, 1'b1);
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input bit wr);
        chk_val({tag, "_nstrobe"}, n_strobe, 1);
        chk_val({tag, "_addr"},    s_addr, a);
        if (wr) chk_val({tag, "_wdata"}, s_wdata, d);
        chk_val({tag, "_be"},      s_be, 4'hF);
        chk_val({tag, "_wstrobe"}, s_wr, wr);
        chk_val({tag, "_rstrobe"}, s_rd, !wr);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] fr[9];
    bit         stable_ok;
    bit         ready_low_ok;

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_data     = 8'h00;
        rsp_ready    = 1'b1;
        io_ready     = 1'b0;
        io_read_data = 32'hFFFF_FFFF;
        clear_mon();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_cmd_ready_held", cmd_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_val("rst_cmd_ready",  cmd_ready, 1'b1);
        chk_val("rst_rsp_valid",  rsp_valid, 1'b0);
        chk_val("rst_rsp_data",   rsp_data, 8'h00);
        chk_val("rst_strobes",    {io_addr_strobe, io_read_strobe, io_write_strobe}, 3'b000);
        chk_val("rst_be",         io_byte_enable, 4'h0);
        chk_val("rst_addr",       io_address, 32'h0);
        chk_val("rst_wdata",      io_write_data, 32'h0);
        @(posedge clk);
        #1;
        $display("[TB] reset state checked");

        // ---- write, io_ready tied high ----
        clear_mon();
        io_ready = 1'b1;
        fr = '{8'h57, 8'hC0, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(fr, 9, 1'b0);
        wait_rsp("wr", 1);
        chk_bus("wr", 32'hC000_0010, 32'hDEAD_BEEF, 1'b1);
        chk_val("wr_rsp0",       rsp_at(0), 8'h4B);
        chk_val("wr_lat_strobe", rise_cyc - s_cyc, 1);
        chk_val("wr_lat_opcode", rise_cyc - op_cyc, 10);
        $display("[TB] write C0000010 <= DEADBEEF, rsp %0d byte(s)", rsp_q.size());

        // ---- read, io_ready pulsed 3 cycles after strobe ----
        clear_mon();
        io_ready = 1'b0;
        fr = '{8'h52, 8'hC0, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 5, 1'b0);
        wait_strobe("rd");
        repeat (3) @(posedge clk);
        #1;
        io_ready     = 1'b1;
        io_read_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        io_ready     = 1'b0;
        io_read_data = 32'hFFFF_FFFF;
        wait_rsp("rd", 5);
        chk_bus("rd", 32'hC000_0004, 32'h0, 1'b0);
        chk_val("rd_rsp0", rsp_at(0), 8'h4B);
        chk_val("rd_rsp1", rsp_at(1), 8'h12);
        chk_val("rd_rsp2", rsp_at(2), 8'h34);
        chk_val("rd_rsp3", rsp_at(3), 8'h56);
        chk_val("rd_rsp4", rsp_at(4), 8'h78);
        chk_val("rd_lat",  rise_cyc - s_cyc, 4);
        $display("[TB] read C0000004, rsp %0d byte(s)", rsp_q.size());

        // ---- timeout ----
        clear_mon();
        fr = '{8'h52, 8'hC0, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 5, 1'b0);
        wait_rsp("tmo", 1);
        chk_val("tmo_rsp0", rsp_at(0), 8'h54);
        chk_val("tmo_lat",  rise_cyc - s_cyc, 8);
        io_ready = 1'b1;
        @(posedge clk);
        #1;
        io_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_val("tmo_late_ready_count", rsp_q.size(), 1);
        chk_val("tmo_late_ready_valid", rsp_valid, 1'b0);
        $display("[TB] read timeout, rsp %0d byte(s)", rsp_q.size());

        // ---- bad opcode, then a normal frame ----
        clear_mon();
        send_byte(8'h33);
        wait_rsp("bad", 1);
        chk_val("bad_rsp0",    rsp_at(0), 8'h45);
        chk_val("bad_nstrobe", n_strobe, 0);
        clear_mon();
        io_ready = 1'b1;
        fr = '{8'h57, 8'hC0, 8'h00, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(fr, 9, 1'b0);
        wait_rsp("after_bad", 1);
        chk_bus("after_bad", 32'hC000_0020, 32'h0102_0304, 1'b1);
        chk_val("after_bad_rsp0", rsp_at(0), 8'h4B);
        $display("[TB] bad opcode 33 then write C0000020, rsp %0d byte(s)", rsp_q.size());

        // ---- response back-pressure ----
        clear_mon();
        rsp_ready    = 1'b0;
        io_ready     = 1'b1;
        io_read_data = 32'hA5C3_0F96;
        fr = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 5, 1'b0);
        wait_strobe("bp");
        @(posedge clk);
        #1;
        io_ready     = 1'b0;
        io_read_data = 32'hFFFF_FFFF;
        chk_val("bp_valid", rsp_valid, 1'b1);
        stable_ok    = 1;
        ready_low_ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_data !== 8'h4B || !rsp_valid) stable_ok = 0;
            if (cmd_ready !== 1'b0) ready_low_ok = 0;
        end
        chk_val("bp_stable",    stable_ok, 1'b1);
        chk_val("bp_cmd_ready", ready_low_ok, 1'b1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp("bp", 5);
        chk_val("bp_rsp0", rsp_at(0), 8'h4B);
        chk_val("bp_rsp1", rsp_at(1), 8'hA5);
        chk_val("bp_rsp2", rsp_at(2), 8'hC3);
        chk_val("bp_rsp3", rsp_at(3), 8'h0F);
        chk_val("bp_rsp4", rsp_at(4), 8'h96);
        $display("[TB] read 00000100 with back-pressure, rsp %0d byte(s)", rsp_q.size());

        // ---- command gaps inside a frame ----
        clear_mon();
        io_ready = 1'b1;
        fr = '{8'h57, 8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send_frame(fr, 9, 1'b1);
        wait_rsp("gap", 1);
        chk_bus("gap", 32'h1234_5678, 32'hCAFE_F00D, 1'b1);
        chk_val("gap_rsp0", rsp_at(0), 8'h4B);
        $display("[TB] write 12345678 <= CAFEF00D with gaps, rsp %0d byte(s)", rsp_q.size());

        // ---- reset during WAIT ----
        clear_mon();
        io_ready = 1'b0;
        fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 5, 1'b0);
        wait_strobe("rstw");
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_val("rstw_strobes",   {io_addr_strobe, io_read_strobe, io_write_strobe}, 3'b000);
        chk_val("rstw_addr",      io_address, 32'h0);
        chk_val("rstw_wdata",     io_write_data, 32'h0);
        chk_val("rstw_rsp_valid", rsp_valid, 1'b0);
        chk_val("rstw_cmd_ready", cmd_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk_val("rstw_no_rsp",       rsp_q.size(), 0);
        chk_val("rstw_idle_ready",   cmd_ready, 1'b1);
        chk_val("rstw_idle_rspv",    rsp_valid, 1'b0);
        $display("[TB] reset during WAIT, stale rsp bytes %0d", rsp_q.size());

        // ---- reset during the strobe cycle ----
        clear_mon();
        fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(fr, 9, 1'b0);
        wait_strobe("rsts");
        #2;
        reset_n = 1'b0;
        #1;
        chk_val("rsts_strobes", {io_addr_strobe, io_read_strobe, io_write_strobe}, 3'b000);
        chk_val("rsts_be",      io_byte_enable, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ---- normal operation after reset ----
        clear_mon();
        io_ready = 1'b1;
        fr = '{8'h57, 8'hC0, 8'h00, 8'h00, 8'h30, 8'h55, 8'hAA, 8'h00, 8'hFF};
        send_frame(fr, 9, 1'b0);
        wait_rsp("post", 1);
        chk_bus("post", 32'hC000_0030, 32'h55AA_00FF, 1'b1);
        chk_val("post_rsp0", rsp_at(0), 8'h4B);
        $display("[TB] write C0000030 <= 55AA00FF after reset, rsp %0d byte(s)", rsp_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mcs_io_master.md
Name: mcs_io_master

Overview:
- Byte-stream-driven initiator for the MCS IO bus: accepts command frames on a byte valid/ready interface and issues single read or write transactions.
- Sits where the MicroBlaze MCS normally sits, in front of mcs_bridge.
- Lets a host (UART rx/tx core upstream) poke FPro MMIO registers without firmware, for bring-up and debug.
- Returns a status byte, plus data for reads, on a response byte stream.

Parameters:
- TIMEOUT, 1024, cycles to wait for io_ready after the strobe cycle before aborting; range 2..65535.
- TW, 16, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_data  in  8  command byte
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  block accepts cmd_data this cycle
- rsp_data  out  8  response byte
- rsp_valid  out  1  rsp_data valid
- rsp_ready  in  1  downstream accepts rsp_data
- io_addr_strobe  out  1  MCS IO address strobe
- io_read_strobe  out  1  MCS IO read strobe
- io_write_strobe  out  1  MCS IO write strobe
- io_byte_enable  out  4  byte enables
- io_address  out  32  byte address
- io_write_data  out  32  write data
- io_read_data  in  32  read data
- io_ready  in  1  transaction complete

Behaviour:
- Reset (async on reset_n low):
  - All outputs 0, including io_address and io_write_data; state IDLE; counters cleared.
  - Reset mid-transaction aborts it silently: no response byte, strobes drop immediately.
- Byte transfers:
  - A command byte transfers when cmd_valid && cmd_ready.
  - A response byte transfers when rsp_valid && rsp_ready.
  - rsp_data is stable while rsp_valid=1 and rsp_ready=0.
- Frame format:
  - Opcode byte: 0x57 = write, 0x52 = read.
  - Then 4 address bytes, MSB first.
  - Write only: 4 data bytes, MSB first.
- Responses:
  - 0x4B (ack).
  - 0x54 (timeout).
  - 0x45 (bad opcode).
  - A read ack is followed by 4 read-data bytes, MSB first.
- FSM states: IDLE, ADDR, WDATA, STROBE, WAIT, RSP.
  - IDLE:
    - cmd_ready=1.
    - On opcode 0x57/0x52: latch op, go ADDR with byte count 0.
    - On any other byte: load 0x45, go RSP with 1 byte.
  - ADDR:
    - cmd_ready=1; shift bytes into the address register, MSB first.
    - After the 4th byte: go WDATA for a write, STROBE for a read.
  - WDATA: cmd_ready=1; shift 4 bytes into the write-data register; after the 4th, go STROBE.
  - STROBE (exactly 1 cycle):
    - io_addr_strobe=1, plus io_write_strobe=1 (write) or io_read_strobe=1 (read).
    - io_byte_enable=4'hF for both reads and writes.
    - io_address / io_write_data already hold the frame values and stay held until the response is loaded.
    - io_ready=1 in this cycle completes the transaction immediately; otherwise go WAIT with the timeout counter at 0.
  - WAIT:
    - Strobes 0; counter increments each cycle.
    - io_ready=1: capture io_read_data (read) and go RSP with ack.
    - Counter reaches TIMEOUT-1 without io_ready: go RSP with 0x54 (1 byte only, including for reads). A late io_ready is ignored.
    - If io_ready and the final timeout cycle coincide, io_ready wins.
  - RSP:
    - rsp_valid=1; holds the byte until accepted.
    - Ack for a read sends 5 bytes total: 0x4B, then rd[31:24], rd[23:16], rd[15:8], rd[7:0].
    - After the last byte transfers, return to IDLE.
- cmd_ready=0 in STROBE, WAIT and RSP. Upstream bytes are back-pressured, never dropped.
- Latency:
  - A write with io_ready held high: rsp_valid rises 1 cycle after the STROBE cycle.
  - That is 10 cycles from the opcode-accept cycle: opcode, 4 addr, 4 data, strobe, then rsp_valid.
- Only one outstanding transaction; no pipelining.
- io_read_data is sampled only on the completing cycle.

Decomposition:
- Package mcs_io_master_pkg:
  - state enum typedef.
  - Opcode constants OP_WR, OP_RD.
  - Response constants RSP_ACK, RSP_TMO, RSP_ERR.
- No sub-module. The shift registers and timeout counter are inline.

Test Plan:
- Write, io_ready tied 1: send 57 C0 00 00 10 DE AD BE EF.
  - Expect one STROBE cycle with io_address=C000_0010, io_write_data=DEAD_BEEF, be=F, write_strobe=1.
  - Response 4B.
- Read, io_ready pulsed 3 cycles after the strobe, io_read_data=1234_5678: send 52 C0 00 00 04.
  - Expect read_strobe=1 for one cycle; response 4B 12 34 56 78.
- Timeout, TIMEOUT=8, io_ready=0: send a read frame.
  - Expect response 54 only, rsp_valid rising 8 cycles after STROBE.
  - A later io_ready pulse causes no extra byte.
- Bad opcode 0x33 -> response 45; the following valid frame is processed normally.
- Back-pressure:
  - Hold rsp_ready=0 for 20 cycles during a read response: byte stable, cmd_ready=0 throughout, no byte lost.
  - Random cmd_valid gaps inside a frame: same bus transaction as the gap-free case.
- Assert reset_n low during WAIT: all strobes and outputs 0 asynchronously; after release, IDLE with cmd_ready=1 and no stale response.
